// File: rtl/h_bridge_driver.sv
// h_bridge_driver: drives one H-bridge from a PWM stream with dead-time, break-before-make and latched fault shutdown.
module h_bridge_driver #(
  parameter int DT_W     = 8,
  parameter int PWM_UNIT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pwm_in,
  input  logic            enable,
  input  logic [1:0]      mode,
  input  logic [DT_W-1:0] dead_time,
  input  logic            fault_n,
  input  logic            fault_clear,
  output logic            hs_a,
  output logic            ls_a,
  output logic            hs_b,
  output logic            ls_b,
  output logic [2:0]      state_out,
  output logic            busy,
  output logic            fault_latched
);
  typedef enum logic [2:0] {IDLE = 3'd0, FWD = 3'd1, REV = 3'd2, BRAKE = 3'd3, SWITCH = 3'd4, FAULT = 3'd5} state_t;
  if (PWM_UNIT < 0) begin : g_bad_unit
  end
  state_t st, nxt, tgt;
  logic pwm_r, ok, hs_leg, ls_leg;
  logic [DT_W-1:0] ecnt, ecnt_n, dcnt, dcnt_n, dmax;
  assign state_out = st;
  always_comb begin
    dmax = (dead_time == '0) ? DT_W'(1) : dead_time;
    tgt = (!enable || mode == 2'b00) ? IDLE : state_t'({1'b0, mode});
    nxt = !fault_n ? FAULT :
          st == FAULT ? (fault_clear ? IDLE : FAULT) :
          st == SWITCH ? ((dcnt == dmax - DT_W'(1)) ? tgt : SWITCH) :
          st == IDLE ? tgt :
          tgt == IDLE ? IDLE :
          tgt != st ? SWITCH : st;
    dcnt_n = (st == SWITCH && nxt == SWITCH) ? dcnt + DT_W'(1) : '0;
    // Gates are computed from next-cycle values so the off-going gate drops on the edge that sees the PWM change.
    ecnt_n = (pwm_r != pwm_in || nxt != st) ? '0 : (ecnt >= dmax) ? ecnt : ecnt + DT_W'(1);
    ok = ecnt_n >= dmax;
    hs_leg = pwm_in & ok;
    ls_leg = ~pwm_in & ok;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      pwm_r <= 1'b0;
      ecnt <= '0;
      dcnt <= '0;
      hs_a <= 1'b0;
      ls_a <= 1'b0;
      hs_b <= 1'b0;
      ls_b <= 1'b0;
      busy <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      st <= nxt;
      pwm_r <= pwm_in;
      ecnt <= ecnt_n;
      dcnt <= dcnt_n;
      hs_a <= (nxt == FWD) & hs_leg;
      ls_a <= ((nxt == FWD) & ls_leg) | (nxt == REV) | (nxt == BRAKE);
      hs_b <= (nxt == REV) & hs_leg;
      ls_b <= ((nxt == REV) & ls_leg) | (nxt == FWD) | (nxt == BRAKE);
      busy <= nxt == SWITCH;
      fault_latched <= nxt == FAULT;
    end
  end
endmodule

// File: tb/tb_h_bridge_driver.sv
// tb_h_bridge_driver: directed vector table plus hand sequences for dead-time, switching and fault corners.
module tb_h_bridge_driver;
  logic clk = 0, reset = 1, pwm_in = 0, enable = 0, fault_n = 1, fault_clear = 0;
  logic [1:0] mode = 0;
  logic [7:0] dead_time = 0;
  logic hs_a, ls_a, hs_b, ls_b, busy, fault_latched;
  logic [2:0] state_out;
  int total = 0, passed = 0;
  logic mon = 0;
  h_bridge_driver #(.DT_W(8), .PWM_UNIT(0)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .enable(enable), .mode(mode),
    .dead_time(dead_time), .fault_n(fault_n), .fault_clear(fault_clear),
    .hs_a(hs_a), .ls_a(ls_a), .hs_b(hs_b), .ls_b(ls_b),
    .state_out(state_out), .busy(busy), .fault_latched(fault_latched)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic en; logic [1:0] md; logic pwm; logic fn; logic clr; logic [7:0] dt;
    logic [3:0] g; logic [2:0] st; logic bz; logic fl;
  } vec_t;
  vec_t vq[$];
  function automatic logic [8:0] outs();
    return {hs_a, ls_a, hs_b, ls_b, state_out, busy, fault_latched};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask
  always @(negedge clk) begin
    if (mon && !reset) begin
      total++;
      if ((hs_a & ls_a) || (hs_b & ls_b) || (fault_latched && {hs_a, ls_a, hs_b, ls_b} != 4'b0) ||
          ((hs_a | ls_a) && (hs_b | ls_b) && !(state_out inside {3'd1, 3'd2, 3'd3})))
        $display("FAIL invariant: gates %b state %0d at %0t", {hs_a, ls_a, hs_b, ls_b}, state_out, $time);
      else passed++;
    end
  end
  initial begin
    int ch, cl, cb, n, g;
    enable = 1; mode = 2'b01; dead_time = 4;
    for (int i = 0; i < 3; i++) begin
      pwm_in = i[0];
      tick();
      chk("reset_hold", outs(), 9'b0);
    end
    reset = 0; pwm_in = 0; enable = 0; mode = 0;
    mon = 1;
    do_reset();
    // en, mode, pwm, fault_n, clear, dt -> gates{hs_a,ls_a,hs_b,ls_b}, state, busy, fault
    vq.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'd2, 4'b0001, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'd2, 4'b0001, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'd2, 4'b0101, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd2, 4'b0001, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd2, 4'b0001, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd2, 4'b1001, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd2, 4'b1001, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'd2, 4'b0001, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd2, 4'b0001, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd2, 4'b0001, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd2, 4'b1001, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 8'd2, 4'b0000, 3'd4, 1'b1, 1'b0});
    vq.push_back('{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 8'd2, 4'b0000, 3'd4, 1'b1, 1'b0});
    vq.push_back('{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 8'd2, 4'b0101, 3'd3, 1'b0, 1'b0});
    vq.push_back('{1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 8'd2, 4'b0000, 3'd0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'd2, 4'b0100, 3'd2, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'd2, 4'b0100, 3'd2, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'd2, 4'b0110, 3'd2, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 8'd2, 4'b0000, 3'd5, 1'b0, 1'b1});
    vq.push_back('{1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 8'd2, 4'b0000, 3'd5, 1'b0, 1'b1});
    vq.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'd2, 4'b0000, 3'd5, 1'b0, 1'b1});
    vq.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'd2, 4'b0000, 3'd0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'd0, 4'b0100, 3'd2, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'd0, 4'b0101, 3'd2, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'd0, 4'b0000, 3'd4, 1'b1, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'd0, 4'b0001, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'd0, 4'b0101, 3'd1, 1'b0, 1'b0});
    foreach (vq[i]) begin
      enable = vq[i].en; mode = vq[i].md; pwm_in = vq[i].pwm;
      fault_n = vq[i].fn; fault_clear = vq[i].clr; dead_time = vq[i].dt;
      tick();
      chk($sformatf("vec%0d", i), outs(), {vq[i].g, vq[i].st, vq[i].bz, vq[i].fl});
    end
    fault_clear = 0; fault_n = 1;
    // dead-time steady state: period 20, on 10, dead_time 4
    do_reset();
    enable = 1; mode = 2'b01; dead_time = 4;
    ch = 0; cl = 0; cb = 0;
    for (int i = 0; i < 100; i++) begin
      pwm_in = (i % 20) < 10;
      tick();
      if (i >= 40) begin
        ch += int'(hs_a); cl += int'(ls_a); cb += int'(ls_b);
      end
    end
    chk("pwm_hs_a_cycles", ch, 18);
    chk("pwm_ls_a_cycles", cl, 18);
    chk("pwm_ls_b_steady", cb, 60);
    // FWD -> REV break-before-make
    pwm_in = 0;
    tick();
    mode = 2'b10;
    tick();
    chk("switch_entry", {busy, state_out}, {1'b1, 3'd4});
    n = 0; g = 0;
    while (busy && g < 12) begin
      if ({hs_a, ls_a, hs_b, ls_b} == 4'b0) n++;
      g++;
      tick();
    end
    chk("switch_len", n, 4);
    chk("switch_exit", {state_out, busy, hs_a, ls_a}, {3'd2, 1'b0, 1'b0, 1'b1});
    // short pulse swallowed
    do_reset();
    enable = 1; mode = 2'b01; dead_time = 4; pwm_in = 0;
    repeat (8) tick();
    chk("pre_pulse_ls_a", ls_a, 1'b1);
    ch = 0; cl = 0;
    for (int i = 0; i < 12; i++) begin
      pwm_in = i < 3;
      tick();
      ch += int'(hs_a); cl += int'(!ls_a);
    end
    chk("short_hs_a", ch, 0);
    chk("short_ls_a_low", cl, 7);
    // fault latch and clear
    pwm_in = 1;
    repeat (6) tick();
    chk("pre_fault_hs_a", hs_a, 1'b1);
    fault_n = 0;
    tick();
    chk("fault_entry", outs(), {4'b0, 3'd5, 1'b0, 1'b1});
    fault_clear = 1;
    tick();
    chk("fault_clear_ignored", outs(), {4'b0, 3'd5, 1'b0, 1'b1});
    fault_n = 1; fault_clear = 0;
    tick();
    chk("fault_held", state_out, 3'd5);
    fault_clear = 1;
    tick();
    chk("fault_cleared", {state_out, fault_latched}, {3'd0, 1'b0});
    fault_clear = 0;
    // brake with dead_time 0, then reset mid-SWITCH
    do_reset();
    enable = 1; mode = 2'b01; dead_time = 0; pwm_in = 0;
    repeat (3) tick();
    mode = 2'b11;
    tick();
    chk("brake_switch", outs(), {4'b0, 3'd4, 1'b1, 1'b0});
    tick();
    chk("brake_on", outs(), {4'b0101, 3'd3, 1'b0, 1'b0});
    mode = 2'b01; dead_time = 4;
    tick();
    tick();
    chk("mid_switch", {state_out, busy}, {3'd4, 1'b1});
    reset = 1;
    tick();
    chk("reset_in_switch", outs(), 9'b0);
    reset = 0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
